loba_acc: RTL and testbench
===========================

# loba_acc

Streaming accumulator that sits directly downstream of the LOBA approximate multiplier. Each accepted beat carries one 2N-bit approximate product. The block sums products over a vector delimited by `in_last`. It then presents the registered sum, beat count and overflow flag on a valid/ready output port. This forms the accumulate half of an approximate MAC datapath.

## Interface
- `N`, default 16: multiplier operand width; the product input is 2N bits.
- `ACC_W`, default 40: accumulator width; must satisfy ACC_W ≥ 2N (elaboration error otherwise).
- `CNT_W`, default 8: beat-counter width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: product beat valid.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `in_p`, input, 2N: unsigned approximate product.
- `in_last`, input, 1: this beat closes the vector.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream consumes the result.
- `out_sum`, output, ACC_W: vector sum.
- `out_count`, output, CNT_W: number of beats accepted in the vector.
- `out_ovf`, output, 1: the sum exceeded 2^ACC_W−1 at any point in the vector.

## Operation
- FSM states: INIT, ACCUM, HOLD.
- **INIT:** `in_ready`=0, `out_valid`=0. Always moves to ACCUM on the next edge. Entered only from reset.
- **ACCUM:** `in_ready`=1. On `in_valid && in_ready`:
  - acc ← acc + zero-extended `in_p`.
  - cnt ← cnt+1, saturating at all-ones.
  - ovf ← ovf | carry-out.
  - If `in_last`=1, the updated acc/cnt/ovf are copied into the output registers, the internal acc/cnt/ovf are cleared, and the FSM moves to HOLD.
- **HOLD:** `in_ready`=0 and `out_valid`=1. Outputs are held stable until `out_ready`=1, then the FSM moves to ACCUM. The internal accumulator is already zero at this point.
- Beats with `in_valid`=0 are ignored. `in_p` and `in_last` are don't-care when no handshake occurs.
- A single-beat vector (`in_last` on the first beat) is legal: `out_count`=1.
- Arithmetic is unsigned with (ACC_W+1)-bit internal add; bit ACC_W is the carry-out.

## Timing
- Reset values:
  - state=INIT.
  - `in_ready`=0, `out_valid`=0.
  - `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - Internal acc, cnt and ovf are 0.
- `in_ready` rises on the first edge after `rst` deasserts. It is decoded from registered state, with no combinational path from `out_ready`.
- Throughput is one beat per cycle within a vector.
- Latency: `out_valid` asserts on the edge that accepts the `in_last` beat, so it is visible the following cycle.
- After the output handshake, `in_ready`=1 in the next cycle. The minimum cost is one bubble cycle per vector; back-to-back overlap is not supported.
- Reset mid-vector or mid-HOLD: the partial sum and the pending result are discarded, and all outputs return to reset values immediately (asynchronously).
- `in_last` on the beat that saturates the counter: `out_count` is all-ones.

## Configuration
- **With `LOBA_ACC_SAT_EN` defined:** on carry-out, acc clamps to all-ones and stays there for the rest of the vector. `out_ovf`=1.
- **Without it:** acc wraps modulo 2^ACC_W. `out_ovf`=1 still flags the wrap.
- The macro affects only the acc update path; the FSM, handshakes and counter are identical in both builds.

## Structure
- Package `loba_pkg`:
  - FSM state enum (INIT/ACCUM/HOLD).
  - Default N/ACC_W/CNT_W localparams.
  - ACC_W ≥ 2N check constant.
- Sub-module `loba_acc_add`:
  - Parameterised ACC_W adder: acc, addend in; sum and carry out.
  - Contains the `LOBA_ACC_SAT_EN` clamp logic, which keeps the FSM module macro-free.

## Test plan
1. **Reset release:** hold `rst` for 3 cycles, then release. Expected: `in_ready`=0 and `out_valid`=0 during reset; `in_ready`=1 exactly one cycle after release.
2. **Basic vector:** beats 100, 200, 300, with `in_last` on 300 and `out_ready`=1. Expected: `out_valid` the next cycle; `out_sum`=600, `out_count`=3, `out_ovf`=0; `in_ready`=1 the following cycle.
3. **Backpressure:** `out_ready`=0 for 5 cycles while `in_valid`=1 with beat 9. Expected: `out_valid` and `out_sum` held stable and `in_ready`=0. After the handshake, the beat 9 with `in_last` yields `out_sum`=9 (no residue).
4. **Overflow (ACC_W=33):** beats 0xFFFFFFFF, 0xFFFFFFFF, 3 (last). Expected:
   - Default build: `out_sum`=0x1, `out_ovf`=1.
   - `LOBA_ACC_SAT_EN` build: `out_sum`=0x1FFFFFFFF, `out_ovf`=1.
5. **Reset mid-vector:** beats 50 and 60, then a 1-cycle `rst` pulse, then beat 7 (last). Expected: `out_sum`=7, `out_count`=1.
6. **Gapped input:** `in_valid` pattern 1,0,0,1,0,1 with beats 4, 5, 6 (last on 6). Expected: `out_sum`=15, `out_count`=3.

Source files
------------

// File: rtl/loba_pkg.sv
// Shared types and defaults for the LOBA accumulate stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package loba_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } loba_state_e;

  localparam int LOBA_N_DEF     = 16;
  localparam int LOBA_ACC_W_DEF = 40;
  localparam int LOBA_CNT_W_DEF = 8;

  function automatic bit acc_w_ok(input int n, input int acc_w);
    return acc_w >= 2 * n;
  endfunction

endpackage

// File: rtl/loba_acc_add.sv
// Accumulator adder with carry-out; LOBA_ACC_SAT_EN clamps the sum to all-ones on carry.
// Latency: combinational.
// Backpressure: none (pure datapath).
module loba_acc_add
  import loba_pkg::*;
#(
  parameter int ACC_W = LOBA_ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, acc} + {1'b0, addend};
  assign carry = raw[ACC_W];

`ifdef LOBA_ACC_SAT_EN
  // Once clamped, any further nonzero addend carries again, so the clamp sticks.
  assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/loba_acc.sv
// Streaming vector accumulator for LOBA products; sum/count/ovf presented on valid/ready.
// Latency: result visible the cycle after the in_last beat is accepted.
// Backpressure: input stalls (in_ready=0) while a result waits in HOLD; one bubble per vector.
module loba_acc
  import loba_pkg::*;
#(
  parameter int N     = LOBA_N_DEF,
  parameter int ACC_W = LOBA_ACC_W_DEF,
  parameter int CNT_W = LOBA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam bit ACC_W_OK = acc_w_ok(N, ACC_W);

  generate
    if (!ACC_W_OK) begin : g_acc_w_chk
      $error("loba_acc: ACC_W must be >= 2*N");
    end
  endgenerate

  loba_state_e state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_nxt;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      INIT: state_nxt = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    addend          = '0;
    addend[2*N-1:0] = in_p;
  end

  loba_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc    (acc),
    .addend (addend),
    .sum    (sum),
    .carry  (carry)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign ovf_nxt = ovf | carry;

  // Closing beat publishes the updated totals and clears the running state in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_sum   <= sum;
        out_count <= cnt_inc;
        out_ovf   <= ovf_nxt;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= sum;
        cnt <= cnt_inc;
        ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_loba_acc.sv
// Directed bench for loba_acc (ACC_W=33 for the overflow case, CNT_W=4 to reach counter saturation).
module tb_loba_acc;
  localparam int N     = 16;
  localparam int ACC_W = 33;
  localparam int CNT_W = 4;

`ifdef LOBA_ACC_SAT_EN
  localparam logic [ACC_W-1:0] OVF_EXP = 33'h1_FFFF_FFFF;
`else
  localparam logic [ACC_W-1:0] OVF_EXP = 33'h0_0000_0001;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*N-1:0]   in_p = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  loba_acc #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Drive one cycle of input starting at a falling edge; returns at the next falling edge.
  task automatic beat(input logic v, input logic [2*N-1:0] p, input logic l);
    in_valid = v;
    in_p     = p;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_hs cycle %0d: got rdy=%b vld=%b expected 0 0", i, in_ready, out_valid);
      end
    end
    tests++;
    if (out_sum !== '0 || out_count !== '0 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL reset_out: got sum=%0h cnt=%0d ovf=%b expected 0 0 0", out_sum, out_count, out_ovf);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL init_rdy: got %b expected 0", in_ready);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL accum_entry: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    beat(1'b1, 32'd100, 1'b0);
    beat(1'b1, 32'd200, 1'b0);
    beat(1'b1, 32'd300, 1'b1);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_hs: got vld=%b rdy=%b expected 1 0", out_valid, in_ready);
    end
    tests++;
    if (out_sum !== 33'd600 || out_count !== 4'd3 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL basic_result: got sum=%0d cnt=%0d ovf=%b expected 600 3 0", out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_return: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(1'b1, 32'd20, 1'b1);
    in_valid = 1'b1; in_p = 32'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 33'd20) begin
        fails++; $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b sum=%0d expected 1 0 20", i, out_valid, in_ready, out_sum);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 33'd9 || out_count !== 4'd1) begin
      fails++; $display("FAIL bp_no_residue: got vld=%b sum=%0d cnt=%0d expected 1 9 1", out_valid, out_sum, out_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    out_ready = 1'b1;
    beat(1'b1, 32'hFFFF_FFFF, 1'b0);
    beat(1'b1, 32'hFFFF_FFFF, 1'b0);
    beat(1'b1, 32'd3, 1'b1);
    in_valid = 1'b0;
    tests++;
    if (out_sum !== OVF_EXP || out_ovf !== 1'b1 || out_count !== 4'd3) begin
      fails++; $display("FAIL overflow: got sum=%0h ovf=%b cnt=%0d expected %0h 1 3", out_sum, out_ovf, out_count, OVF_EXP);
    end
    @(negedge clk);
  endtask

  task automatic test_count_sat;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) beat(1'b1, 32'd1, (i == 19));
    in_valid = 1'b0;
    tests++;
    if (out_count !== 4'hF || out_sum !== 33'd20 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL count_sat: got cnt=%0d sum=%0d ovf=%b expected 15 20 0", out_count, out_sum, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    beat(1'b1, 32'd50, 1'b0);
    beat(1'b1, 32'd60, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_mid_rdy: got %b expected 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    beat(1'b1, 32'd7, 1'b1);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 33'd7 || out_count !== 4'd1) begin
      fails++; $display("FAIL rst_mid_result: got vld=%b sum=%0d cnt=%0d expected 1 7 1", out_valid, out_sum, out_count);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
      fails++; $display("FAIL rst_hold_async: got vld=%b sum=%0d cnt=%0d expected 0 0 0", out_valid, out_sum, out_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
  endtask

  task automatic test_gapped;
    out_ready = 1'b1;
    beat(1'b1, 32'd4,  1'b0);
    beat(1'b0, 32'd99, 1'b1);
    beat(1'b0, 32'd99, 1'b1);
    beat(1'b1, 32'd5,  1'b0);
    beat(1'b0, 32'd99, 1'b1);
    beat(1'b1, 32'd6,  1'b1);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 33'd15 || out_count !== 4'd3 || out_ovf !== 1'b0) begin
      fails++; $display("FAIL gapped: got vld=%b sum=%0d cnt=%0d ovf=%b expected 1 15 3 0", out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_count_sat();
    test_reset_mid();
    test_gapped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
